// File: rtl/dsp_branch_unit_pkg.sv
// Shared definitions for the branch/loop controller.
// Provides the default address width, the branch opcode encodings and a
// small helper that evaluates conditional branch outcomes.
package dsp_branch_unit_pkg;

  localparam int MEM_ADDR_LEN = 16;

  typedef enum logic [2:0] {
    BR_NOP  = 3'd0,
    BR_JMP  = 3'd1,
    BR_JZ   = 3'd2,
    BR_JNZ  = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5,
    BR_LOOP = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  // JZ takes on a set zero flag, JNZ on a clear one.
  function automatic logic cond_taken(input br_op_e op, input logic zf);
    return (op == BR_JZ) ? zf : !zf;
  endfunction

endpackage

// File: rtl/dsp_branch_unit_lifo.sv
// dsp_lifo: small stack used for the return-address and loop stacks.
// Ports:
//   clk, rst    clock and synchronous active-high reset (clears occupancy)
//   push, pop   stack operations; both together replace the top entry
//   wdata       entry to push
//   rdata       combinational view of the top entry (zero when empty)
//   full, empty occupancy flags
// A push while full (without a pop) is dropped; a pop while empty is ignored.
module dsp_lifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_m1;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    wr_idx;
  logic             replace;
  logic             do_write;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign cnt_m1   = cnt - CW'(1);
  assign top_idx  = IW'(cnt_m1);
  assign replace  = push && pop && !empty;
  assign wr_idx   = replace ? top_idx : IW'(cnt);
  assign do_write = replace || (push && !full);
  assign rdata    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (replace) begin
      cnt <= cnt;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt_m1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/dsp_branch_unit.sv
// dsp_branch_unit: branch/loop controller driving the Fetch jump interface.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   inst_valid   decoded instruction present this cycle
//   inst_pc      address of the decoded instruction
//   br_op        branch opcode (see br_op_e)
//   br_target    jump/call target; for LOOP the last body address
//   loop_count   LOOP iteration count
//   zero_flag    ALU zero flag for JZ/JNZ
//   jump_addr    registered redirect address
//   jump_flag    registered one-cycle redirect strobe (also squashes Decode)
//   loop_active  loop stack non-empty
//   rstack_err   sticky return-stack overflow/underflow
//   lstack_err   sticky loop-stack overflow
module dsp_branch_unit
  import dsp_branch_unit_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_LEN,
  parameter int CNT_W        = 16,
  parameter int RSTACK_DEPTH = 8,
  parameter int LSTACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic [ADDR_W-1:0] inst_pc,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [CNT_W-1:0]  loop_count,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              jump_flag,
  output logic              loop_active,
  output logic              rstack_err,
  output logic              lstack_err
);

  localparam int LW = 2 * ADDR_W + CNT_W;

  br_op_e            op_p0;
  logic              act_p0;
  logic              jump_p0;
  logic [ADDR_W-1:0] jump_addr_p0;
  logic              rs_err_set_p0;
  logic              ls_err_set_p0;
  logic              jump_vld_p1;
  logic [ADDR_W-1:0] jump_addr_p1;

  logic              rs_push, rs_pop, rs_full, rs_empty;
  logic [ADDR_W-1:0] rs_wdata, rs_rdata;
  logic              ls_push, ls_pop, ls_full, ls_empty;
  logic [LW-1:0]     ls_wdata, ls_rdata;

  logic [ADDR_W-1:0] top_start, top_end;
  logic [CNT_W-1:0]  top_cnt;

  dsp_lifo #(.WIDTH(ADDR_W), .DEPTH(RSTACK_DEPTH)) u_rstack (
    .clk(clk), .rst(rst), .push(rs_push), .pop(rs_pop), .wdata(rs_wdata),
    .rdata(rs_rdata), .full(rs_full), .empty(rs_empty)
  );

  dsp_lifo #(.WIDTH(LW), .DEPTH(LSTACK_DEPTH)) u_lstack (
    .clk(clk), .rst(rst), .push(ls_push), .pop(ls_pop), .wdata(ls_wdata),
    .rdata(ls_rdata), .full(ls_full), .empty(ls_empty)
  );

  // Loop entries are packed {start, end, count}, start in the MSBs.
  assign top_start = ls_rdata[LW-1 -: ADDR_W];
  assign top_end   = ls_rdata[CNT_W +: ADDR_W];
  assign top_cnt   = ls_rdata[CNT_W-1:0];

  // Stage p0: decode and decide; an outstanding redirect squashes the input.
  assign op_p0  = br_op_e'(br_op);
  assign act_p0 = inst_valid && !jump_vld_p1;

  always_comb begin
    jump_p0       = 1'b0;
    jump_addr_p0  = br_target;
    rs_push       = 1'b0;
    rs_pop        = 1'b0;
    rs_wdata      = inst_pc + ADDR_W'(1);
    ls_push       = 1'b0;
    ls_pop        = 1'b0;
    ls_wdata      = {inst_pc + ADDR_W'(1), br_target, loop_count};
    rs_err_set_p0 = 1'b0;
    ls_err_set_p0 = 1'b0;
    if (act_p0) begin
      case (op_p0)
        BR_JMP:  jump_p0 = 1'b1;
        BR_JZ,
        BR_JNZ:  jump_p0 = cond_taken(op_p0, zero_flag);
        BR_CALL: begin
          jump_p0       = 1'b1;
          rs_push       = 1'b1;
          rs_err_set_p0 = rs_full;
        end
        BR_RET: begin
          if (rs_empty) begin
            rs_err_set_p0 = 1'b1;
          end else begin
            rs_pop       = 1'b1;
            jump_p0      = 1'b1;
            jump_addr_p0 = rs_rdata;
          end
        end
        BR_LOOP: begin
          if (loop_count == '0) begin
            jump_p0      = 1'b1;
            jump_addr_p0 = br_target + ADDR_W'(1);
          end else begin
            ls_push       = 1'b1;
            ls_err_set_p0 = ls_full;
          end
        end
        default: ;
      endcase
      // Loop-end handling yields to any taken branch and to a new LOOP.
      if (!jump_p0 && op_p0 != BR_LOOP && !ls_empty && inst_pc == top_end) begin
        ls_pop = 1'b1;
        if (top_cnt > CNT_W'(1)) begin
          ls_push      = 1'b1;
          ls_wdata     = {top_start, top_end, top_cnt - CNT_W'(1)};
          jump_p0      = 1'b1;
          jump_addr_p0 = top_start;
        end
      end
    end
  end

  // Stage p1: registered redirect and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_vld_p1  <= 1'b0;
      jump_addr_p1 <= '0;
      rstack_err   <= 1'b0;
      lstack_err   <= 1'b0;
    end else begin
      jump_vld_p1 <= jump_p0;
      if (jump_p0) jump_addr_p1 <= jump_addr_p0;
      if (rs_err_set_p0) rstack_err <= 1'b1;
      if (ls_err_set_p0) lstack_err <= 1'b1;
    end
  end

  assign jump_flag   = jump_vld_p1;
  assign jump_addr   = jump_addr_p1;
  assign loop_active = !ls_empty;

endmodule

// File: tb/tb_dsp_branch_unit.sv
// Directed testbench for dsp_branch_unit.
module tb_dsp_branch_unit;
  import dsp_branch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [15:0] inst_pc = '0;
  logic [2:0]  br_op = '0;
  logic [15:0] br_target = '0;
  logic [15:0] loop_count = '0;
  logic        zero_flag = 1'b0;
  logic [15:0] jump_addr;
  logic        jump_flag;
  logic        loop_active;
  logic        rstack_err;
  logic        lstack_err;

  int checks = 0;
  int failures = 0;
  int prog_sel = 0;
  int hits, jumps;

  dsp_branch_unit dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .br_op(br_op), .br_target(br_target), .loop_count(loop_count),
    .zero_flag(zero_flag), .jump_addr(jump_addr), .jump_flag(jump_flag),
    .loop_active(loop_active), .rstack_err(rstack_err), .lstack_err(lstack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_inst(input br_op_e op, input logic [15:0] pc, input logic [15:0] tgt,
                         input logic [15:0] cnt, input logic zf);
    inst_valid = 1'b1;
    br_op      = op;
    inst_pc    = pc;
    br_target  = tgt;
    loop_count = cnt;
    zero_flag  = zf;
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic idle();
    inst_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    inst_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Walks a tiny program, following redirects; counts visits of one pc and jumps.
  task automatic run_prog(input logic [15:0] start, input logic [15:0] stop,
                          input logic [15:0] watch, output int nhits, output int njumps);
    logic [15:0] pc;
    pc = start;
    nhits = 0;
    njumps = 0;
    for (int s = 0; s < 200 && pc != stop; s++) begin
      if (pc == watch) nhits++;
      if (prog_sel == 0 && pc == 16'h0020)      do_inst(BR_LOOP, pc, 16'h0023, 16'd3, 1'b0);
      else if (prog_sel == 1 && pc == 16'h0040) do_inst(BR_LOOP, pc, 16'h0045, 16'd2, 1'b0);
      else if (prog_sel == 1 && pc == 16'h0041) do_inst(BR_LOOP, pc, 16'h0043, 16'd3, 1'b0);
      else                                      do_inst(BR_NOP, pc, 16'h0000, 16'd0, 1'b0);
      if (jump_flag) begin
        njumps++;
        pc = jump_addr;
        idle();
      end else begin
        pc = pc + 16'd1;
      end
    end
    check("prog_reached_end", {16'h0, pc}, {16'h0, stop});
  endtask

  initial begin
    reset_dut();
    check("rst_jump_flag", {31'h0, jump_flag}, 32'h0);
    check("rst_jump_addr", {16'h0, jump_addr}, 32'h0);
    check("rst_loop_active", {31'h0, loop_active}, 32'h0);
    check("rst_rstack_err", {31'h0, rstack_err}, 32'h0);
    check("rst_lstack_err", {31'h0, lstack_err}, 32'h0);

    // JMP and squash of the following instruction
    do_inst(BR_JMP, 16'h0010, 16'h0040, 16'd0, 1'b0);
    check("jmp_flag", {31'h0, jump_flag}, 32'h1);
    check("jmp_addr", {16'h0, jump_addr}, 32'h0040);
    do_inst(BR_JMP, 16'h0011, 16'h0080, 16'd0, 1'b0);
    check("squash_flag", {31'h0, jump_flag}, 32'h0);
    check("squash_addr", {16'h0, jump_addr}, 32'h0040);

    // Conditional branches
    do_inst(BR_JZ, 16'h0012, 16'h0050, 16'd0, 1'b0);
    check("jz_not_taken", {31'h0, jump_flag}, 32'h0);
    do_inst(BR_JNZ, 16'h0013, 16'h0022, 16'd0, 1'b0);
    check("jnz_flag", {31'h0, jump_flag}, 32'h1);
    check("jnz_addr", {16'h0, jump_addr}, 32'h0022);
    idle();
    check("one_cycle_strobe", {31'h0, jump_flag}, 32'h0);

    // CALL / RET
    do_inst(BR_CALL, 16'h0005, 16'h0100, 16'd0, 1'b0);
    check("call_flag", {31'h0, jump_flag}, 32'h1);
    check("call_addr", {16'h0, jump_addr}, 32'h0100);
    idle();
    do_inst(BR_RET, 16'h0104, 16'h0000, 16'd0, 1'b0);
    check("ret_flag", {31'h0, jump_flag}, 32'h1);
    check("ret_addr", {16'h0, jump_addr}, 32'h0006);
    idle();

    // Single loop, 3 iterations
    prog_sel = 0;
    run_prog(16'h0020, 16'h0024, 16'h0021, hits, jumps);
    check("loop3_jumps", jumps, 2);
    check("loop3_body", hits, 3);
    check("loop3_inactive", {31'h0, loop_active}, 32'h0);

    // Zero-count loop skips the body
    do_inst(BR_LOOP, 16'h002F, 16'h0030, 16'd0, 1'b0);
    check("loop0_flag", {31'h0, jump_flag}, 32'h1);
    check("loop0_addr", {16'h0, jump_addr}, 32'h0031);
    check("loop0_no_push", {31'h0, loop_active}, 32'h0);
    idle();

    // Nested 2 x 3
    prog_sel = 1;
    run_prog(16'h0040, 16'h0046, 16'h0042, hits, jumps);
    check("nest_body", hits, 6);
    check("nest_jumps", jumps, 5);
    check("nest_inactive", {31'h0, loop_active}, 32'h0);

    // Taken branch at loop end wins; count untouched
    do_inst(BR_LOOP, 16'h0060, 16'h0062, 16'd2, 1'b0);
    check("prio_active", {31'h0, loop_active}, 32'h1);
    do_inst(BR_JMP, 16'h0062, 16'h0070, 16'd0, 1'b0);
    check("prio_addr", {16'h0, jump_addr}, 32'h0070);
    idle();
    do_inst(BR_NOP, 16'h0062, 16'h0000, 16'd0, 1'b0);
    check("prio_loop_flag", {31'h0, jump_flag}, 32'h1);
    check("prio_loop_addr", {16'h0, jump_addr}, 32'h0061);
    idle();
    do_inst(BR_NOP, 16'h0062, 16'h0000, 16'd0, 1'b0);
    check("prio_exit_flag", {31'h0, jump_flag}, 32'h0);
    check("prio_exit_active", {31'h0, loop_active}, 32'h0);

    // Return-stack overflow
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      do_inst(BR_CALL, 16'h0200 + 16'(i), 16'h0300, 16'd0, 1'b0);
      check("ovf_call_flag", {31'h0, jump_flag}, 32'h1);
      check("ovf_err", {31'h0, rstack_err}, (i == 8) ? 32'h1 : 32'h0);
      idle();
    end
    do_inst(BR_RET, 16'h0400, 16'h0000, 16'd0, 1'b0);
    check("ovf_ret_addr", {16'h0, jump_addr}, 32'h0208);
    idle();

    // Return-stack underflow
    reset_dut();
    do_inst(BR_RET, 16'h0010, 16'h0000, 16'd0, 1'b0);
    check("udf_no_jump", {31'h0, jump_flag}, 32'h0);
    check("udf_err", {31'h0, rstack_err}, 32'h1);

    // Loop-stack overflow
    reset_dut();
    for (int i = 0; i < 5; i++)
      do_inst(BR_LOOP, 16'h0500 + 16'(i), 16'h0600 + 16'(i), 16'd2, 1'b0);
    check("lovf_err", {31'h0, lstack_err}, 32'h1);
    check("lovf_active", {31'h0, loop_active}, 32'h1);

    // Reset mid-loop with a jump decided on the same edge
    inst_valid = 1'b1;
    br_op = BR_JMP;
    inst_pc = 16'h0700;
    br_target = 16'h0800;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    inst_valid = 1'b0;
    check("rst_mid_flag", {31'h0, jump_flag}, 32'h0);
    check("rst_mid_active", {31'h0, loop_active}, 32'h0);
    check("rst_mid_lerr", {31'h0, lstack_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
